// File: rtl/fifo_mc_pkg.sv
// Width helpers shared by the multi-channel FIFO and its memory.
package fifo_mc_pkg;

   function automatic int unsigned ch_w(input int unsigned num_channels);
      return (num_channels > 1) ? $clog2(num_channels) : 1;
   endfunction

   function automatic int unsigned ptr_w(input int unsigned ch_depth);
      return (ch_depth > 1) ? $clog2(ch_depth) : 1;
   endfunction

   function automatic int unsigned cnt_w(input int unsigned ch_depth);
      return ptr_w(ch_depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_mc_mem.sv
// Simple dual-port memory with byte write mask; registered read unless SHOWAHEAD.
module fifo_mc_mem #(
   parameter int unsigned WIDTH     = 512,
   parameter int unsigned DEPTH     = 4096,
   parameter int unsigned SHOWAHEAD = 0,
   localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned MASK_W   = WIDTH / 8
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic [MASK_W-1:0] wr_mask,
   input  logic              rd_en,
   input  logic [AW-1:0]     rd_addr,
   output logic [WIDTH-1:0]  rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < int'(MASK_W); b++) begin
            if (wr_mask[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
         end
      end
   end

   generate
      if (SHOWAHEAD != 0) begin : g_showahead
         assign rd_data = mem[rd_addr];
      end else begin : g_registered
         always_ff @(posedge clk) begin
            if (rd_en) rd_data <= mem[rd_addr];
         end
      end
   endgenerate

endmodule

// File: rtl/fifo_mc.sv
// Multi-channel FIFO: NUM_CHANNELS queues partitioned inside one shared memory.
module fifo_mc
   import fifo_mc_pkg::*;
#(
   parameter int unsigned FIFO_WIDTH_BYTES = 64,
   parameter int unsigned NUM_CHANNELS     = 4,
   parameter int unsigned CH_DEPTH         = 1024,
   parameter int unsigned AFULL_LEVEL      = CH_DEPTH / 2,
   localparam int unsigned CH_W            = ch_w(NUM_CHANNELS),
   localparam int unsigned DATA_W          = FIFO_WIDTH_BYTES * 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    write_in,
   input  logic [CH_W-1:0]         write_ch_in,
   input  logic [DATA_W-1:0]       write_data_in,
   input  logic                    read_in,
   input  logic [CH_W-1:0]         read_ch_in,
   output logic [DATA_W-1:0]       read_data_out,
   output logic                    read_valid_out,
   output logic [NUM_CHANNELS-1:0] empty_out,
   output logic [NUM_CHANNELS-1:0] full_out,
   output logic [NUM_CHANNELS-1:0] afull_out,
   input  logic                    clear_in,
   input  logic [CH_W-1:0]         clear_ch_in,
   output logic                    overflow_out,
   output logic                    underflow_out,
   input  logic                    debugen_in
);

   localparam int unsigned PTR_W  = ptr_w(CH_DEPTH);
   localparam int unsigned CNT_W  = cnt_w(CH_DEPTH);
   localparam int unsigned ADDR_W = CH_W + PTR_W;
   localparam int unsigned MASK_W = DATA_W / 8;

   logic [PTR_W-1:0] wp  [NUM_CHANNELS];
   logic [PTR_W-1:0] rp  [NUM_CHANNELS];
   logic [CNT_W-1:0] cnt [NUM_CHANNELS];

   logic wr_clr_hit, rd_clr_hit, wr_acc, rd_acc;

   // A clear on the addressed channel silently wins over the access.
   assign wr_clr_hit = clear_in && (clear_ch_in == write_ch_in);
   assign rd_clr_hit = clear_in && (clear_ch_in == read_ch_in);
   assign wr_acc     = write_in && !full_out[write_ch_in] && !wr_clr_hit;
   assign rd_acc     = read_in && !empty_out[read_ch_in] && !rd_clr_hit;

   generate
      for (genvar c = 0; c < int'(NUM_CHANNELS); c++) begin : g_ch
         logic [PTR_W-1:0] wp_q, rp_q;
         logic [CNT_W-1:0] cnt_q;
         logic             wr_hit, rd_hit, clr_hit;

         assign wr_hit  = wr_acc && (write_ch_in == CH_W'(c));
         assign rd_hit  = rd_acc && (read_ch_in == CH_W'(c));
         assign clr_hit = clear_in && (clear_ch_in == CH_W'(c));

         always_ff @(posedge clk) begin
            if (reset || clr_hit) begin
               wp_q  <= '0;
               rp_q  <= '0;
               cnt_q <= '0;
            end else begin
               if (wr_hit) wp_q <= wp_q + PTR_W'(1);
               if (rd_hit) rp_q <= rp_q + PTR_W'(1);
               cnt_q <= cnt_q + CNT_W'(wr_hit) - CNT_W'(rd_hit);
            end
         end

         assign wp[c]        = wp_q;
         assign rp[c]        = rp_q;
         assign cnt[c]       = cnt_q;
         assign empty_out[c] = (cnt_q == '0);
         assign full_out[c]  = (cnt_q == CNT_W'(CH_DEPTH));
         assign afull_out[c] = (cnt_q >= CNT_W'(AFULL_LEVEL));
      end
   endgenerate

   logic [ADDR_W-1:0] wr_addr, rd_addr;
   assign wr_addr = {write_ch_in, wp[write_ch_in]};
   assign rd_addr = {read_ch_in, rp[read_ch_in]};

   fifo_mc_mem #(
      .WIDTH     (DATA_W),
      .DEPTH     (NUM_CHANNELS * CH_DEPTH),
      .SHOWAHEAD (0)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_acc),
      .wr_addr (wr_addr),
      .wr_data (write_data_in),
      .wr_mask ({MASK_W{1'b1}}),
      .rd_en   (rd_acc),
      .rd_addr (rd_addr),
      .rd_data (read_data_out)
   );

   // Read strobe and sticky error flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         read_valid_out <= 1'b0;
         overflow_out   <= 1'b0;
         underflow_out  <= 1'b0;
      end else begin
         read_valid_out <= rd_acc;
         if (write_in && full_out[write_ch_in] && !wr_clr_hit) overflow_out <= 1'b1;
         if (read_in && empty_out[read_ch_in] && !rd_clr_hit) underflow_out <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (debugen_in) begin
         $write("[fifo_mc] wr=%0b wch=%0d wacc=%0b wcnt=%0d | rd=%0b rch=%0d racc=%0b rcnt=%0d\n",
                write_in, write_ch_in, wr_acc, cnt[write_ch_in],
                read_in, read_ch_in, rd_acc, cnt[read_ch_in]);
      end
   end

endmodule
